tas_avg_writer: RTL and testbench

//  Parametrised successor to the serial temperature-averaging receiver. Deserialises an LSB-first
//  bit stream into bytes and frames them into packets: 1 header byte + N_DATA payload bytes.

---
 rtl/tas_avg_writer.sv | 169 ++++++++++++++++
 tb/tb_tas_avg_writer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tas_avg_writer.sv
// Serial packet receiver: deserialises LSB-first bytes, frames header + N_DATA payload bytes,
// and writes the payload average to RAM at a decrementing, wrapping address.
module tas_avg_writer #(
    parameter int          N_DATA   = 4,
    parameter int          ADDR_W   = 11,
    parameter logic [7:0]  HDR_A    = 8'hA5,
    parameter logic [7:0]  HDR_B    = 8'hC3,
    parameter int          ROUND    = 0,
    parameter int          IDLE_CYC = 16
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              serial_data,
    input  logic              data_ena,
    output logic              ram_wr_n,
    output logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              hdr_err
);

    localparam int LOG_N  = $clog2(N_DATA);
    localparam int SUM_W  = 8 + LOG_N;
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int RND    = (ROUND != 0) ? (N_DATA / 2) : 0;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_PAY   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          byte_r;
    logic [LOG_N-1:0]    byte_cnt_r, byte_cnt_nxt_s;
    logic [SUM_W-1:0]    sum_r, sum_nxt_s;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                byte_done_s;
    logic [7:0]          full_byte_s;
    logic                hdr_match_s;
    logic                idle_hit_s;
    logic                hdr_err_nxt_s;
    logic                wr_fire_s;
    logic [SUM_W:0]      rnd_sum_s;
    logic [7:0]          avg_s;

    // Clamp a widened average to one byte.
    function automatic logic [7:0] sat8(input logic [SUM_W:0] v);
        if (v > (SUM_W + 1)'(255)) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    assign byte_done_s = data_ena && (bit_cnt_r == 3'd7);
    assign full_byte_s = {serial_data, byte_r[6:0]};
    assign hdr_match_s = (full_byte_s == HDR_A) || (full_byte_s == HDR_B);
    assign idle_hit_s  = !data_ena && (idle_cnt_r == IDLE_W'(IDLE_CYC - 1));
    assign rnd_sum_s   = {1'b0, sum_r} + (SUM_W + 1)'(RND);
    assign avg_s       = sat8(rnd_sum_s >> LOG_N);

    // Bit deserialiser; a long idle gap drops any partial byte.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r <= 3'd0;
            byte_r    <= 8'h00;
        end else if (data_ena) begin
            bit_cnt_r         <= bit_cnt_r + 3'd1;
            byte_r[bit_cnt_r] <= serial_data;
        end else if (idle_hit_s) begin
            bit_cnt_r <= 3'd0;
            byte_r    <= 8'h00;
        end
    end

    // Idle-gap counter, saturating once the resync threshold is reached.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= IDLE_W'(0);
        end else if (data_ena) begin
            idle_cnt_r <= IDLE_W'(0);
        end else if (idle_cnt_r != IDLE_W'(IDLE_CYC)) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end
    end

    // Framing FSM next-state, accumulator and header-check logic.
    always_comb begin
        state_nxt_s    = state_r;
        sum_nxt_s      = sum_r;
        byte_cnt_nxt_s = byte_cnt_r;
        hdr_err_nxt_s  = 1'b0;
        wr_fire_s      = 1'b0;
        case (state_r)
            ST_HDR, ST_WRITE: begin
                wr_fire_s   = (state_r == ST_WRITE);
                state_nxt_s = ST_HDR;
                if (byte_done_s) begin
                    if (hdr_match_s) begin
                        sum_nxt_s      = {SUM_W{1'b0}};
                        byte_cnt_nxt_s = {LOG_N{1'b0}};
                        state_nxt_s    = ST_PAY;
                    end else begin
                        hdr_err_nxt_s  = 1'b1;
                    end
                end else begin
                    hdr_err_nxt_s = 1'b0;
                end
            end
            ST_PAY: begin
                if (byte_done_s) begin
                    sum_nxt_s      = sum_r + SUM_W'(full_byte_s);
                    byte_cnt_nxt_s = byte_cnt_r + LOG_N'(1);
                    if (byte_cnt_r == LOG_N'(N_DATA - 1)) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_PAY;
                    end
                end else begin
                    state_nxt_s = ST_PAY;
                end
            end
            default: begin
                state_nxt_s = ST_HDR;
            end
        endcase
        // A pending write is never cancelled by the idle resync.
        if (idle_hit_s && (state_r != ST_WRITE)) begin
            state_nxt_s = ST_HDR;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Framing state, accumulator and byte counter registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_HDR;
            sum_r      <= {SUM_W{1'b0}};
            byte_cnt_r <= {LOG_N{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            sum_r      <= sum_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
        end
    end

    // Registered RAM interface; the address counter steps on each strobe.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            ram_wr_n <= 1'b1;
            ram_data <= 8'h00;
            ram_addr <= {ADDR_W{1'b1}};
            addr_r   <= {ADDR_W{1'b1}};
            hdr_err  <= 1'b0;
        end else begin
            ram_wr_n <= !wr_fire_s;
            hdr_err  <= hdr_err_nxt_s;
            if (wr_fire_s) begin
                ram_data <= avg_s;
                ram_addr <= addr_r;
                addr_r   <= addr_r - ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tas_avg_writer.sv
// Randomised and directed bench for tas_avg_writer: three instances (truncate, round, narrow address)
// share one serial stream and are checked against a byte-level packet model.
module tb_tas_avg_writer;

    localparam int N = 4;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        serial_data = 1'b0;
    logic        data_ena = 1'b0;

    logic        wr0, wr1, wr2, he0, he1, he2;
    logic [7:0]  d0, d1, d2;
    logic [10:0] a0, a1;
    logic [3:0]  a2;

    int vectors = 0;
    int miscompares = 0;

    logic [18:0] q0[$];
    logic [7:0]  q1[$];
    logic [3:0]  q2[$];
    logic [10:0] m_addr0;
    logic [3:0]  m_addr2;
    int          hdr_seen = 0;
    int          hdr_exp  = 0;
    logic        prev_wr0 = 1'b1;

    always #10 clk_50 = ~clk_50;

    tas_avg_writer #(.N_DATA(N), .ADDR_W(11), .ROUND(0)) u0 (
        .clk_50(clk_50), .reset_n(reset_n), .serial_data(serial_data), .data_ena(data_ena),
        .ram_wr_n(wr0), .ram_data(d0), .ram_addr(a0), .hdr_err(he0));
    tas_avg_writer #(.N_DATA(N), .ADDR_W(11), .ROUND(1)) u1 (
        .clk_50(clk_50), .reset_n(reset_n), .serial_data(serial_data), .data_ena(data_ena),
        .ram_wr_n(wr1), .ram_data(d1), .ram_addr(a1), .hdr_err(he1));
    tas_avg_writer #(.N_DATA(N), .ADDR_W(4), .ROUND(0)) u2 (
        .clk_50(clk_50), .reset_n(reset_n), .serial_data(serial_data), .data_ena(data_ena),
        .ram_wr_n(wr2), .ram_data(d2), .ram_addr(a2), .hdr_err(he2));

    function automatic int avg_model(input int sum, input bit rnd);
        int a;
        a = rnd ? (2 * sum + N) / (2 * N) : sum / N;
        return (a > 255) ? 255 : a;
    endfunction

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk_50) begin
        if (he0) hdr_seen++;
        if (!wr0) begin
            vectors++;
            assert (prev_wr0) else begin
                miscompares++; $error("FAIL strobe_width obs=wide exp=1cycle");
            end
            vectors++;
            assert (q0.size() != 0) else begin
                miscompares++; $error("FAIL unexpected_write0 obs addr=%h data=%h exp=none", a0, d0);
            end
            if (q0.size() != 0) begin
                logic [18:0] e;
                e = q0.pop_front();
                vectors++;
                assert ({a0, d0} === e) else begin
                    miscompares++; $error("FAIL write0 obs=%h/%h exp=%h/%h", a0, d0, e[18:8], e[7:0]);
                end
            end
        end
        if (!wr1) begin
            logic [7:0] e1;
            e1 = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
            vectors++;
            assert ({a1, d1} === {a0, e1}) else begin
                miscompares++; $error("FAIL write1_round obs=%h/%h exp=%h/%h", a1, d1, a0, e1);
            end
        end
        if (!wr2) begin
            logic [3:0] e2;
            e2 = (q2.size() != 0) ? q2.pop_front() : 4'hx;
            vectors++;
            assert ({a2, d2} === {e2, d0}) else begin
                miscompares++; $error("FAIL write2_wrap obs=%h/%h exp=%h/%h", a2, d2, e2, d0);
            end
        end
        prev_wr0 = wr0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk_50);
        data_ena = 1'b1;
        serial_data = b;
        @(negedge clk_50);
        data_ena = 1'b0;
        repeat (gap) @(negedge clk_50);
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        for (int i = 0; i < 8; i++) send_bit(v[i], $urandom_range(maxgap, 0));
    endtask

    // Model a packet, then serialise it. Rejected headers are sent alone.
    task automatic send_packet(input logic [7:0] hdr, input logic [8*N-1:0] pl, input int maxgap);
        int sum;
        if (hdr == 8'hA5 || hdr == 8'hC3) begin
            sum = 0;
            for (int i = 0; i < N; i++) sum += int'(pl[8*i +: 8]);
            q0.push_back({m_addr0, 8'(avg_model(sum, 1'b0))});
            q1.push_back(8'(avg_model(sum, 1'b1)));
            q2.push_back(m_addr2);
            m_addr0 = m_addr0 - 11'd1;
            m_addr2 = m_addr2 - 4'd1;
            send_byte(hdr, maxgap);
            for (int i = 0; i < N; i++) send_byte(pl[8*i +: 8], maxgap);
        end else begin
            hdr_exp++;
            send_byte(hdr, maxgap);
        end
    endtask

    initial begin
        logic [7:0] h;
        m_addr0 = 11'h7FF;
        m_addr2 = 4'hF;
        #25;
        check("reset_wr_n", {31'd0, wr0}, 32'd1);
        check("reset_data", {24'd0, d0}, 32'd0);
        check("reset_addr", {21'd0, a0}, 32'h7FF);
        check("reset_hdr_err", {31'd0, he0}, 32'd0);
        check("reset_addr_narrow", {28'd0, a2}, 32'hF);
        @(negedge clk_50);
        reset_n = 1'b1;

        // Directed: basic packet with exact strobe latency.
        send_packet(8'hA5, {8'h40, 8'h30, 8'h20, 8'h10}, 0);
        check("latency_early", {31'd0, wr0}, 32'd1);
        @(negedge clk_50);
        check("latency_strobe", {31'd0, wr0}, 32'd0);
        check("latency_data", {24'd0, d0}, 32'h28);
        repeat (2) @(negedge clk_50);
        check("hold_data", {24'd0, d0}, 32'h28);
        check("hold_addr", {21'd0, a0}, 32'h7FF);
        send_packet(8'h5A, '0, 0);
        send_packet(8'hC3, {4{8'hFF}}, 1);
        send_packet(8'hA5, {8'h00, 8'h01, 8'h01, 8'h01}, 2);
        repeat (4) @(negedge clk_50);
        check("hdr_err_count", 32'(hdr_seen), 32'(hdr_exp));

        // Randomised packets with short bit gaps; enough to wrap the narrow address.
        for (int p = 0; p < 40; p++) begin
            h = ($urandom_range(4, 0) == 0) ? 8'($urandom) : (($urandom_range(1, 0) != 0) ? 8'hA5 : 8'hC3);
            send_packet(h, {$urandom}, 3);
        end
        repeat (4) @(negedge clk_50);

        // Idle resync: partial packet abandoned after exactly IDLE_CYC quiet cycles.
        send_byte(8'hA5, 0);
        send_byte(8'h11, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        repeat (15) @(negedge clk_50);
        send_packet(8'hC3, {8'h80, 8'h60, 8'h40, 8'h20}, 0);
        repeat (4) @(negedge clk_50);
        check("idle_queue_empty", 32'(q0.size()), 32'd0);

        // Reset mid-payload aborts the packet and restores the address.
        send_byte(8'hA5, 0);
        send_byte(8'h77, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_wr_n", {31'd0, wr0}, 32'd1);
        check("midreset_data", {24'd0, d0}, 32'd0);
        check("midreset_addr", {21'd0, a0}, 32'h7FF);
        m_addr0 = 11'h7FF;
        m_addr2 = 4'hF;
        @(negedge clk_50);
        reset_n = 1'b1;
        send_packet(8'hA5, {8'h09, 8'h07, 8'h05, 8'h03}, 1);
        repeat (4) @(negedge clk_50);

        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);
        check("final_q2_empty", 32'(q2.size()), 32'd0);
        check("final_hdr_err", 32'(hdr_seen), 32'(hdr_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
